product_shift_adder: RTL and testbench

//  Iterative unsigned shift-add multiply engine. It sits directly downstream of the Multiplicand register and consumes multiplicand_out.

---
 rtl/mult_pkg.sv | 17 +
 rtl/carry_adder.sv | 17 +
 rtl/product_shift_adder.sv | 99 +++++++++
 tb/tb_product_shift_adder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the unsigned shift-add multiplier family.
package mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    // Iteration counter width for a given operand width.
    function automatic int unsigned COUNT_W(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/carry_adder.sv
// Unsigned WIDTH + WIDTH -> WIDTH+1 adder; the top bit is the carry out.
module carry_adder
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   sum_o
);

    // Zero-extend both operands so the carry is kept in the result.
    always_comb begin
        sum_o = {1'b0, a_i} + {1'b0, b_i};
    end

endmodule

// File: rtl/product_shift_adder.sv
// Iterative shift-add multiplier: one W x W -> 2W unsigned product every W cycles.
module product_shift_adder
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand_in,
    input  logic [WIDTH-1:0]   multiplier_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product_out
);

    localparam int unsigned     CW   = COUNT_W(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    mult_state_e        state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;

    // Add the multiplicand into the upper half when the current multiplier bit is set.
    always_comb begin
        addend = work_q[0] ? mcand_q : '0;
    end

    carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a_i   (work_q[2*WIDTH-1:WIDTH]),
        .b_i   (addend),
        .sum_o (sum)
    );

    // State, counter, operand latch, work register and product hold register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            work_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mcand_q   <= mcand_d;
            work_q    <= work_d;
            product_q <= product_d;
        end
    end

    // Next-state, datapath update and product capture on the final iteration.
    // The carry of each add is shifted straight into the work MSB, so the
    // register never needs a separate carry position that outlives one cycle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        work_d    = work_q;
        product_d = product_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = multiplicand_in;
                    work_d  = {{WIDTH{1'b0}}, multiplier_in};
                    count_d = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                work_d  = {sum, work_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    product_d = work_d;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        busy        = (state_q == ST_CALC);
        done        = (state_q == ST_DONE);
        product_out = product_q;
    end

endmodule

// File: tb/tb_product_shift_adder.sv
// Directed self-checking bench for product_shift_adder (WIDTH = 32).
module tb_product_shift_adder;

    localparam int unsigned W = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand_in;
    logic [W-1:0]   multiplier_in;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product_out;

    int tests  = 0;
    int failed = 0;

    product_shift_adder #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
        .busy            (busy),
        .done            (done),
        .product_out     (product_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Step until done rises (bounded); report cycles taken and busy cycles seen.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bcnt++;
            tick();
            cyc++;
        end
    endtask

    task automatic run_mult(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [63:0] exp);
        int cyc;
        int bcnt;
        multiplicand_in = a;
        multiplier_in   = b;
        start           = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_on_accept"}, busy, 1);
        wait_done(cyc, bcnt);
        check({tag, "_latency"}, cyc, 32);
        check({tag, "_busy_cycles"}, bcnt, 32);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_product"}, product_out, exp);
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int cyc;
        int bcnt;
        int dcnt;

        // 1) reset, then idle without start
        rst = 1'b0;
        start = 1'b0;
        multiplicand_in = '0;
        multiplier_in = '0;
        tick();
        tick();
        rst = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product_out, 0);
        tick(); tick(); tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // 2) 3 x 5
        run_mult("m3x5", 32'd3, 32'd5, 64'h0F);

        // 3) all ones
        run_mult("mFFxFF", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

        // 4) 7 x 9 with an ignored start and operand change at cycle 10
        multiplicand_in = 32'd7;
        multiplier_in   = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        dcnt = 0;
        while (cyc < 40) begin
            if (cyc == 10) begin
                multiplicand_in = 32'd2;
                multiplier_in   = 32'd2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
            if (done === 1'b1) begin
                dcnt++;
                if (dcnt == 1) begin
                    check("ign_latency", cyc, 32);
                    check("ign_product", product_out, 64'd63);
                end
            end
        end
        check("ign_single_done", dcnt, 1);
        check("ign_product_held", product_out, 64'd63);

        // 5) reset at iteration 16 of 12 x 12
        multiplicand_in = 32'd12;
        multiplier_in   = 32'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("midrst_busy_before", busy, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", product_out, 0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        run_mult("m12x12", 32'd12, 32'd12, 64'd144);

        // 6) back-to-back with start held high
        multiplicand_in = 32'd0;
        multiplier_in   = 32'h1234;
        start = 1'b1;
        tick();
        multiplicand_in = 32'h1_0000;
        multiplier_in   = 32'h1_0000;
        check("b2b_first_busy", busy, 1);
        wait_done(cyc, bcnt);
        check("b2b_first_latency", cyc, 32);
        check("b2b_first_product", product_out, 64'd0);
        tick();
        check("b2b_gap_busy", busy, 0);
        check("b2b_gap_done", done, 0);
        tick();
        start = 1'b0;
        check("b2b_second_accept", busy, 1);
        wait_done(cyc, bcnt);
        check("b2b_second_latency", cyc, 32);
        check("b2b_second_product", product_out, 64'h1_0000_0000);
        tick();
        check("b2b_second_done_end", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
